// File: rtl/psum_drain_acc_ctrl_pkg.sv
// Shared types and constants for the partial-sum drain/accumulate sequencer.
// Holds the FSM state encoding and the PMEM address-space fit check.
package psum_drain_acc_ctrl_pkg;

    localparam int unsigned COL     = 8;
    localparam int unsigned PSUM_BW = 16;

    typedef enum logic [2:0] {
        StIdle,
        StDrain,
        StDrainTail,
        StAcc,
        StAccTail
    } state_e;

    // True when every (kij, onij) pair has its own PMEM word.
    function automatic bit addr_fits(int unsigned n_kij, int unsigned n_onij, int unsigned aw);
        return (longint'(n_kij) * longint'(n_onij)) <= (longint'(1) << aw);
    endfunction

endpackage

// File: rtl/psum_addr_gen.sv
// PMEM address generator: o/k counters plus a running k*len_onij (or kij*len_onij) base.
// The FSM only issues load/clear/step; no multiplier sits in the address path.
module psum_addr_gen
    import psum_drain_acc_ctrl_pkg::*;
#(
    parameter int unsigned len_kij  = 9,
    parameter int unsigned len_onij = 16,
    parameter int unsigned addr_w   = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_drain,
    input  logic [3:0]        kij,
    input  logic              clear,
    input  logic              step_drain,
    input  logic              step_acc,
    output logic [addr_w-1:0] addr,
    output logic [addr_w-1:0] o,
    output logic              first_k,
    output logic              last_k,
    output logic              last_o
);

    localparam int unsigned KW = (len_kij > 1) ? $clog2(len_kij) : 1;
    localparam logic [addr_w-1:0] ONIJ = addr_w'(len_onij);

    logic [KW-1:0]     k_q, k_d;
    logic [addr_w-1:0] base_q, base_d;
    logic [addr_w-1:0] o_q, o_d;
    logic [addr_w-1:0] kij_base;

    // kij*len_onij as a chain of conditional adds of the constant row stride.
    always_comb begin
        kij_base = '0;
        for (int i = 0; i < int'(len_kij); i++) begin
            if (i < int'(kij)) begin
                kij_base = kij_base + ONIJ;
            end
        end
    end

    always_comb begin
        k_d    = k_q;
        base_d = base_q;
        o_d    = o_q;
        if (load_drain) begin
            k_d    = '0;
            o_d    = '0;
            base_d = kij_base;
        end else if (clear) begin
            k_d    = '0;
            o_d    = '0;
            base_d = '0;
        end else if (step_drain) begin
            o_d = o_q + addr_w'(1);
        end else if (step_acc) begin
            if (last_k) begin
                k_d    = '0;
                base_d = '0;
                o_d    = o_q + addr_w'(1);
            end else begin
                k_d    = k_q + KW'(1);
                base_d = base_q + ONIJ;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            k_q    <= '0;
            base_q <= '0;
            o_q    <= '0;
        end else begin
            k_q    <= k_d;
            base_q <= base_d;
            o_q    <= o_d;
        end
    end

    assign addr    = base_q + o_q;
    assign o       = o_q;
    assign first_k = (k_q == '0);
    assign last_k  = (k_q == KW'(len_kij - 1));
    assign last_o  = (o_q == addr_w'(len_onij - 1));

endmodule

// File: rtl/psum_drain_acc_ctrl.sv
// Drains corelet OFIFO rows into PMEM per kij pass, then streams all partial sums
// of each output pixel back into the per-column SFP accumulators.
module psum_drain_acc_ctrl
    import psum_drain_acc_ctrl_pkg::*;
#(
    parameter int unsigned col      = COL,
    parameter int unsigned psum_bw  = PSUM_BW,
    parameter int unsigned len_kij  = 9,
    parameter int unsigned len_onij = 16,
    parameter int unsigned addr_w   = 11
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start_drain,
    input  logic [3:0]               kij_idx,
    input  logic                     start_acc,
    input  logic                     ofifo_valid,
    output logic                     ofifo_rd,
    input  logic [col*psum_bw-1:0]   ofifo_data,
    output logic                     pmem_wen,
    output logic                     pmem_ren,
    output logic [addr_w-1:0]        pmem_addr,
    output logic [col*psum_bw-1:0]   pmem_wdata,
    input  logic [col*psum_bw-1:0]   pmem_rdata,
    output logic [col*psum_bw-1:0]   psum_addition,
    output logic                     acc_input,
    output logic                     acc_first,
    output logic                     out_valid,
    output logic [addr_w-1:0]        out_idx,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);

    localparam int unsigned CW = $clog2(len_onij + 1);

    if (!addr_fits(len_kij, len_onij, addr_w)) begin : g_addr_check
        $error("psum_drain_acc_ctrl: len_kij*len_onij does not fit in addr_w bits");
    end

    state_e            state_q, state_d;
    logic [CW-1:0]     rd_cnt_q, rd_cnt_d;
    logic              rd_d_q;
    logic              ren_d_q, first_d_q, last_d_q;
    logic [addr_w-1:0] o_d_q;
    logic              out_valid_q;
    logic [addr_w-1:0] out_idx_q;
    logic              err_q, err_d;

    logic              ag_load, ag_clear, ag_step_drain, ag_step_acc;
    logic [addr_w-1:0] ag_addr, ag_o;
    logic              ag_first_k, ag_last_k, ag_last_o;

    psum_addr_gen #(
        .len_kij  (len_kij),
        .len_onij (len_onij),
        .addr_w   (addr_w)
    ) u_addr_gen (
        .clk        (clk),
        .reset      (reset),
        .load_drain (ag_load),
        .kij        (kij_idx),
        .clear      (ag_clear),
        .step_drain (ag_step_drain),
        .step_acc   (ag_step_acc),
        .addr       (ag_addr),
        .o          (ag_o),
        .first_k    (ag_first_k),
        .last_k     (ag_last_k),
        .last_o     (ag_last_o)
    );

    always_comb begin
        state_d       = state_q;
        rd_cnt_d      = rd_cnt_q;
        ofifo_rd      = 1'b0;
        pmem_ren      = 1'b0;
        ag_load       = 1'b0;
        ag_clear      = 1'b0;
        ag_step_drain = 1'b0;
        ag_step_acc   = 1'b0;
        err_d         = 1'b0;
        done          = 1'b0;
        unique case (state_q)
            StIdle: begin
                // Drain has priority; a coincident start_acc is dropped.
                if (start_drain) begin
                    if (32'(kij_idx) < len_kij) begin
                        state_d  = StDrain;
                        ag_load  = 1'b1;
                        rd_cnt_d = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (start_acc) begin
                    state_d  = StAcc;
                    ag_clear = 1'b1;
                end
            end
            StDrain: begin
                ofifo_rd      = ofifo_valid && (rd_cnt_q < CW'(len_onij));
                ag_step_drain = rd_d_q;
                if (ofifo_rd) begin
                    rd_cnt_d = rd_cnt_q + CW'(1);
                    if (rd_cnt_q == CW'(len_onij - 1)) begin
                        state_d = StDrainTail;
                    end
                end
            end
            StDrainTail: begin
                ag_step_drain = rd_d_q;
                done          = 1'b1;
                state_d       = StIdle;
            end
            StAcc: begin
                pmem_ren    = 1'b1;
                ag_step_acc = 1'b1;
                if (ag_last_k && ag_last_o) begin
                    state_d = StAccTail;
                end
            end
            StAccTail: begin
                // Only the final pixel's out_valid can land here.
                if (out_valid_q) begin
                    done    = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            rd_cnt_q    <= '0;
            rd_d_q      <= 1'b0;
            ren_d_q     <= 1'b0;
            first_d_q   <= 1'b0;
            last_d_q    <= 1'b0;
            o_d_q       <= '0;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_cnt_q    <= rd_cnt_d;
            rd_d_q      <= ofifo_rd;
            ren_d_q     <= pmem_ren;
            first_d_q   <= pmem_ren && ag_first_k;
            last_d_q    <= pmem_ren && ag_last_k;
            out_valid_q <= last_d_q;
            err_q       <= err_d;
            if (pmem_ren) begin
                o_d_q <= ag_o;
            end
            if (last_d_q) begin
                out_idx_q <= o_d_q;
            end
        end
    end

    assign pmem_wen      = rd_d_q;
    assign pmem_wdata    = rd_d_q ? ofifo_data : '0;
    assign pmem_addr     = (rd_d_q || pmem_ren) ? ag_addr : '0;
    assign psum_addition = pmem_rdata;
    assign acc_input     = ren_d_q;
    assign acc_first     = first_d_q;
    assign out_valid     = out_valid_q;
    assign out_idx       = out_valid_q ? out_idx_q : '0;
    assign busy          = (state_q != StIdle);
    assign err           = err_q;

endmodule

// File: tb/tb_psum_drain_acc_ctrl.sv
// Directed bench for psum_drain_acc_ctrl with OFIFO/PMEM/SFP models and a scoreboard.
module tb_psum_drain_acc_ctrl;

    localparam int COLS = 8;
    localparam int BW   = 16;
    localparam int LK   = 9;
    localparam int LO   = 16;
    localparam int AW   = 11;
    localparam int DW   = COLS * BW;

    logic          clk = 1'b0;
    logic          reset;
    logic          start_drain, start_acc, ofifo_valid;
    logic [3:0]    kij_idx;
    logic          ofifo_rd, pmem_wen, pmem_ren;
    logic [DW-1:0] ofifo_data = '0;
    logic [DW-1:0] pmem_rdata = '0;
    logic [DW-1:0] pmem_wdata, psum_addition;
    logic [AW-1:0] pmem_addr, out_idx;
    logic          acc_input, acc_first, out_valid, busy, done, err;

    always #5 clk = ~clk;

    psum_drain_acc_ctrl #(
        .col      (COLS),
        .psum_bw  (BW),
        .len_kij  (LK),
        .len_onij (LO),
        .addr_w   (AW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start_drain   (start_drain),
        .kij_idx       (kij_idx),
        .start_acc     (start_acc),
        .ofifo_valid   (ofifo_valid),
        .ofifo_rd      (ofifo_rd),
        .ofifo_data    (ofifo_data),
        .pmem_wen      (pmem_wen),
        .pmem_ren      (pmem_ren),
        .pmem_addr     (pmem_addr),
        .pmem_wdata    (pmem_wdata),
        .pmem_rdata    (pmem_rdata),
        .psum_addition (psum_addition),
        .acc_input     (acc_input),
        .acc_first     (acc_first),
        .out_valid     (out_valid),
        .out_idx       (out_idx),
        .busy          (busy),
        .done          (done),
        .err           (err)
    );

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    int            n_cmp = 0, n_bad = 0;
    int            cyc = 0, pop_n = 0, pop_base = 0, seed = 0;
    logic [AW-1:0] exp_base = '0;
    wr_t           exp_wr[$];
    logic [AW-1:0] exp_rd[$];
    int            exp_out[$];
    wr_t           e_wr;
    int            wr_n = 0, ren_n = 0, acc_n = 0, first_n = 0, ov_n = 0;
    int            done_n = 0, err_n = 0, done_cyc = 0, s_cyc = 0;
    logic [DW-1:0] mem [0:2047];
    logic [DW-1:0] sfp_vec = '0;
    logic [158:0]  outs;

    assign outs = {ofifo_rd, pmem_wen, pmem_ren, pmem_addr, pmem_wdata, acc_input, acc_first,
                   out_valid, out_idx, busy, done, err};

    function automatic logic [DW-1:0] row(input int n, input int s);
        logic [DW-1:0] r;
        for (int c = 0; c < COLS; c++) r[c*BW +: BW] = 16'(s * 256 + n * 16 + c);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // OFIFO model: each pop presents the next row and books its expected PMEM write.
    always @(posedge clk) begin
        if (ofifo_rd) begin
            ofifo_data <= row(pop_n - pop_base, seed);
            exp_wr.push_back(wr_t'{exp_base + AW'(pop_n - pop_base), row(pop_n - pop_base, seed)});
            pop_n <= pop_n + 1;
        end
    end

    always @(posedge clk) begin
        if (pmem_wen) mem[pmem_addr] <= pmem_wdata;
        if (pmem_ren) pmem_rdata <= mem[pmem_addr];
    end

    // SFP model: load on the first term, add otherwise.
    always @(posedge clk) begin
        if (acc_input) begin
            for (int c = 0; c < COLS; c++) begin
                sfp_vec[c*BW +: BW] <= acc_first ? psum_addition[c*BW +: BW]
                                                 : sfp_vec[c*BW +: BW] + psum_addition[c*BW +: BW];
            end
        end
    end

    always @(negedge clk) begin
        if (pmem_wen) begin
            wr_n++;
            if (exp_wr.size() == 0) chk("wr_unexpected", 1, 0);
            else begin
                e_wr = exp_wr.pop_front();
                chk("wr_addr", pmem_addr, e_wr.a);
                chk("wr_data", pmem_wdata, e_wr.d);
            end
        end
        if (pmem_ren) begin
            ren_n++;
            if (exp_rd.size() == 0) chk("rd_unexpected", 1, 0);
            else chk("rd_addr", pmem_addr, exp_rd.pop_front());
        end
        if (acc_input) begin
            chk("acc_first", acc_first, (acc_n % LK) == 0);
            acc_n++;
            if (acc_first) first_n++;
        end
        if (out_valid) begin
            ov_n++;
            if (exp_out.size() == 0) chk("ov_unexpected", 1, 0);
            else begin
                chk("out_idx", out_idx, exp_out.pop_front());
                chk("sfp_sum", sfp_vec, {COLS{16'd45}});
            end
        end
        if (done) begin
            done_n++;
            done_cyc = cyc;
        end
        if (err) err_n++;
    end

    task automatic wait_done(input int max_cyc, input int d0);
        for (int i = 0; i < max_cyc && done_n == d0; i++) begin
            @(posedge clk);
            #1;
        end
        chk("done_seen", done_n > d0, 1);
    endtask

    // mode: 0 plain, 1 OFIFO gap after 4th pop, 2 start_acc mid-drain, 3 start_acc with start
    task automatic run_drain(input int kij, input int sd, input int lat, input int mode);
        int w0, r0, d0;
        exp_base = AW'(kij * LO);
        seed     = sd;
        pop_base = pop_n;
        w0 = wr_n; r0 = ren_n; d0 = done_n;
        ofifo_valid = 1'b1;
        start_drain = 1'b1;
        kij_idx     = 4'(kij);
        start_acc   = (mode == 3);
        s_cyc       = cyc;
        @(posedge clk);
        #1;
        start_drain = 1'b0;
        start_acc   = 1'b0;
        chk("drain_busy", busy, 1);
        if (mode == 1) begin
            for (int i = 0; i < 40 && (pop_n - pop_base) < 4; i++) begin
                @(posedge clk);
                #1;
            end
            ofifo_valid = 1'b0;
            repeat (5) @(posedge clk);
            #1;
            ofifo_valid = 1'b1;
        end else if (mode == 2) begin
            repeat (5) @(posedge clk);
            #1;
            start_acc = 1'b1;
            @(posedge clk);
            #1;
            start_acc = 1'b0;
        end
        wait_done(80, d0);
        chk("drain_latency", done_cyc - s_cyc, lat);
        chk("drain_writes", wr_n - w0, LO);
        chk("drain_sb_empty", exp_wr.size(), 0);
        chk("drain_no_ren", ren_n - r0, 0);
        @(posedge clk);
        #1;
        chk("drain_idle", busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int e0, a0, d0;
        reset = 1'b0;
        start_drain = 1'b0;
        start_acc = 1'b0;
        ofifo_valid = 1'b0;
        kij_idx = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", outs, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Reset mid-drain with the OFIFO still offering data.
        exp_base = '0;
        seed = 1;
        pop_base = pop_n;
        ofifo_valid = 1'b1;
        start_drain = 1'b1;
        kij_idx = 4'd0;
        @(posedge clk);
        #1;
        start_drain = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("abort_outputs", outs, 0);
        exp_wr.delete();
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_idle", busy, 0);

        run_drain(2, 2, 17, 0);
        run_drain(2, 3, 22, 1);

        // Out-of-range kij is rejected.
        e0 = err_n;
        start_drain = 1'b1;
        kij_idx = 4'd9;
        @(posedge clk);
        #1;
        start_drain = 1'b0;
        chk("err_pulse", err, 1);
        chk("err_busy", busy, 0);
        @(posedge clk);
        #1;
        chk("err_one_cycle", err, 0);
        chk("err_count", err_n - e0, 1);
        chk("err_still_idle", busy, 0);

        run_drain(1, 4, 17, 3);
        run_drain(3, 5, 17, 2);

        // Accumulation: word k*16+o holds k+1 in every column.
        for (int k = 0; k < LK; k++)
            for (int o = 0; o < LO; o++) mem[k * LO + o] = {COLS{16'(k + 1)}};
        for (int o = 0; o < LO; o++) begin
            for (int k = 0; k < LK; k++) exp_rd.push_back(AW'(k * LO + o));
            exp_out.push_back(o);
        end
        a0 = acc_n;
        d0 = done_n;
        e0 = wr_n;
        start_acc = 1'b1;
        s_cyc = cyc;
        @(posedge clk);
        #1;
        start_acc = 1'b0;
        chk("acc_busy", busy, 1);
        wait_done(300, d0);
        chk("acc_latency", done_cyc - s_cyc, LK * LO + 2);
        chk("acc_count", acc_n - a0, LK * LO);
        chk("acc_first_count", first_n, LO);
        chk("out_valid_count", ov_n, LO);
        chk("rd_sb_empty", exp_rd.size(), 0);
        chk("out_sb_empty", exp_out.size(), 0);
        chk("acc_no_writes", wr_n - e0, 0);
        @(posedge clk);
        #1;
        chk("acc_idle", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/psum_drain_acc_ctrl.md
Name: psum_drain_acc_ctrl

Overview:
- Sequencer directly downstream of the corelet.
- DRAIN phase: empties the corelet OFIFO into the partial-sum memory (PMEM), one row of col psums per output pixel, at an address derived from the current kernel index kij.
- ACCUM phase: reads back all len_kij partial sums for each output pixel and streams them into the corelet's per-column SFP accumulators (psum_addition / acc_input), flagging when each pixel's final sum is ready.

Parameters:
- col, 8, output channels per PMEM word.
- psum_bw, 16, bits per psum.
- len_kij, 9, kernel positions accumulated per output pixel.
- len_onij, 16, output pixels per kij pass.
- addr_w, 11, PMEM address width; must satisfy len_kij*len_onij <= 2**addr_w.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start_drain  in  1  pulse: drain one kij pass.
- kij_idx  in  4  kij of the pass being drained; sampled on start_drain.
- start_acc  in  1  pulse: run the accumulation phase.
- ofifo_valid  in  1  OFIFO holds at least one row.
- ofifo_rd  out  1  OFIFO pop.
- ofifo_data  in  col*psum_bw  OFIFO row; valid the cycle after ofifo_rd.
- pmem_wen  out  1  PMEM write strobe.
- pmem_ren  out  1  PMEM read strobe; rdata valid next cycle.
- pmem_addr  out  addr_w  PMEM address.
- pmem_wdata  out  col*psum_bw  PMEM write data.
- pmem_rdata  in  col*psum_bw  PMEM read data.
- psum_addition  out  col*psum_bw  data to SFPs; equals pmem_rdata.
- acc_input  out  1  SFP accumulate enable.
- acc_first  out  1  with acc_input: first term of a pixel (SFP loads instead of adds).
- out_valid  out  1  SFP outputs hold the final sum of pixel out_idx.
- out_idx  out  addr_w  pixel index for out_valid.
- busy  out  1  not IDLE.
- done  out  1  one-cycle pulse at the end of a phase.
- err  out  1  one-cycle pulse: start_drain rejected.

Behaviour:
- Reset (reset=0, async): state IDLE, all counters 0, all outputs 0.
- FSM states: IDLE, DRAIN, DRAIN_TAIL, ACC, ACC_TAIL.
- IDLE transitions:
  - start_drain with kij_idx < len_kij: latch kij_idx, go to DRAIN.
  - start_drain with kij_idx >= len_kij: pulse err, stay IDLE.
  - start_drain and start_acc in the same cycle: drain wins; start_acc is dropped.
  - Starts outside IDLE are ignored; no err.
- DRAIN:
  - ofifo_rd = ofifo_valid && rd_cnt < len_onij.
  - rd_d = ofifo_rd delayed one cycle.
  - When rd_d=1: pmem_wen=1, pmem_wdata=ofifo_data, pmem_addr=kij*len_onij+wr_cnt, then wr_cnt++.
  - If ofifo_valid drops, the phase stalls with no write and no timeout.
  - After the len_onij-th pop, go to DRAIN_TAIL. In DRAIN_TAIL, perform the final write, pulse done, return to IDLE.
  - Latency: last pop to done = 1 cycle.
- ACC:
  - Nested counters: o over 0..len_onij-1 (outer), k over 0..len_kij-1 (inner).
  - Each cycle: pmem_ren=1, pmem_addr=k*len_onij+o. Stall-free, one read per cycle.
  - Addresses computed with counters and adders; no multiplier in the address path.
  - After the final read (o=len_onij-1, k=len_kij-1), go to ACC_TAIL.
- SFP alignment (registered, 1 cycle after ren):
  - acc_input = ren_d.
  - acc_first = ren_d && k_d==0.
  - psum_addition = pmem_rdata (combinational pass-through).
- out_valid pulses 2 cycles after the read with k=len_kij-1, to cover the SFP register; out_idx = that read's o.
- ACC_TAIL: waits for the last out_valid, pulses done in the same cycle, returns to IDLE.
- Total ACC phase: len_kij*len_onij + 2 cycles from start_acc to done.
- Width rules: no arithmetic on psum data in this block; all addresses are computed in addr_w bits.
- Reset mid-phase: immediate return to IDLE. PMEM contents and OFIFO contents are undefined for the host to recover.

Decomposition:
- Shared package holds:
  - FSM state enum;
  - PSUM_BW, COL;
  - the address-width check expression.
- One sub-module: psum_addr_gen. It owns the k/o counters and the kij*len_onij+o address generation for both phases, so the FSM only issues step/clear.

Test Plan:
1. Reset held low mid-DRAIN with ofifo_valid=1 -> all outputs 0 immediately; IDLE after release; next start_drain works normally.
2. start_drain, kij_idx=2, ofifo_valid constant 1, rows D0..D15 -> 16 writes at addr 32..47 with wdata=Dn; done 1 cycle after the last pop.
3. Same as test 2 but ofifo_valid low for 5 cycles after the 4th pop -> no pmem_wen during the gap; addresses continuous 32..47; done delayed exactly 5 cycles.
4. Preload PMEM addr a=k*16+o with value k+1 in every column, then start_acc -> reads ordered o-major; acc_first on every 9th acc; out_valid 16 times, out_idx 0..15; SFP model sums = 45 per column; done at cycle 146.
5. start_drain with kij_idx=9 -> err pulse, busy stays 0. start_drain and start_acc in the same cycle -> DRAIN entered and start_acc ignored.
6. start_acc asserted during DRAIN -> ignored; drain completes; no pmem_ren observed.
